// File: rtl/biquad_cascade.sv
// Time-multiplexed cascade of direct-form-I biquad sections sharing one signed MAC.
// Coefficients load through a shadow bank and are committed only between samples.
module biquad_cascade #(
    parameter int DATA_W  = 32,
    parameter int Q_FP    = 15,
    parameter int N_BANDS = 4,
    parameter int CADDR_W = $clog2(N_BANDS) + 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_W-1:0]    o_data,
    input  logic                 i_cwe,
    input  logic [CADDR_W-1:0]   i_caddr,
    input  logic [DATA_W-1:0]    i_cdata,
    input  logic                 i_commit,
    input  logic                 i_clear,
    input  logic                 i_bypass
);
    localparam int ACC_W  = 2 * DATA_W + 4;
    localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam logic signed [DATA_W-1:0] UNITY   = {{(DATA_W-Q_FP-1){1'b0}}, 1'b1, {Q_FP{1'b0}}};
    localparam logic signed [ACC_W-1:0]  RND     = {{(ACC_W-Q_FP){1'b0}}, 1'b1, {(Q_FP-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

    state_t                     r_state;
    logic signed [DATA_W-1:0]   r_sh  [N_BANDS][5];
    logic signed [DATA_W-1:0]   r_act [N_BANDS][5];
    logic signed [DATA_W-1:0]   w_sh_nxt [N_BANDS][5];
    logic signed [DATA_W-1:0]   r_x1 [N_BANDS];
    logic signed [DATA_W-1:0]   r_x2 [N_BANDS];
    logic signed [DATA_W-1:0]   r_y1 [N_BANDS];
    logic signed [DATA_W-1:0]   r_y2 [N_BANDS];
    logic signed [DATA_W-1:0]   r_x;
    logic                       r_bypass;
    logic [BAND_W-1:0]          r_band;
    logic [2:0]                 r_term;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_commit_pend;
    logic                       r_clear_pend;
    logic                       r_o_ready;
    logic                       r_o_valid;
    logic [DATA_W-1:0]          r_o_data;

    logic [CADDR_W-1:0]         w_cband;
    logic signed [DATA_W-1:0]   w_coef;
    logic signed [DATA_W-1:0]   w_op;
    logic                       w_neg;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_rnd;
    logic signed [ACC_W-1:0]    w_shr;
    logic signed [DATA_W-1:0]   w_y;
    logic                       w_do_commit;
    logic                       w_do_clear;

    assign w_cband     = i_caddr >> 3'd3;
    assign w_do_commit = r_commit_pend | i_commit;
    assign w_do_clear  = r_clear_pend | i_clear;

    // Shadow bank as it will look after this cycle's write, so a same-cycle commit sees the new value.
    always_comb begin
        w_sh_nxt = r_sh;
        for (int b = 0; b < N_BANDS; b++) begin
            for (int c = 0; c < 5; c++) begin
                if (i_cwe && (w_cband == CADDR_W'(b)) && (i_caddr[2:0] == 3'(c))) begin
                    w_sh_nxt[b][c] = i_cdata;
                end else begin
                    w_sh_nxt[b][c] = r_sh[b][c];
                end
            end
        end
    end

    // Coefficient/operand select for the current term; feedback terms are subtracted.
    always_comb begin
        w_coef = '0;
        w_op   = '0;
        w_neg  = 1'b0;
        case (r_term)
            3'd0: begin w_coef = r_act[r_band][0]; w_op = r_x;          end
            3'd1: begin w_coef = r_act[r_band][1]; w_op = r_x1[r_band]; end
            3'd2: begin w_coef = r_act[r_band][2]; w_op = r_x2[r_band]; end
            3'd3: begin w_coef = r_act[r_band][3]; w_op = r_y1[r_band]; w_neg = 1'b1; end
            3'd4: begin w_coef = r_act[r_band][4]; w_op = r_y2[r_band]; w_neg = 1'b1; end
            default: begin w_coef = '0; w_op = '0; w_neg = 1'b0; end
        endcase
    end

    assign w_prod     = w_coef * w_op;
    assign w_prod_ext = {{4{w_prod[2*DATA_W-1]}}, w_prod};
    assign w_term     = w_neg ? -w_prod_ext : w_prod_ext;
    assign w_rnd      = r_acc + RND;
    assign w_shr      = w_rnd >>> Q_FP;

    // Round-half-up then saturate the section result to the sample range.
    always_comb begin
        if (w_shr > SAT_MAX) begin
            w_y = SAT_MAX[DATA_W-1:0];
        end else if (w_shr < SAT_MIN) begin
            w_y = SAT_MIN[DATA_W-1:0];
        end else begin
            w_y = w_shr[DATA_W-1:0];
        end
    end

    // Sequencer, coefficient banks, section history and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_band        <= '0;
            r_term        <= 3'd0;
            r_acc         <= '0;
            r_x           <= '0;
            r_bypass      <= 1'b0;
            r_commit_pend <= 1'b0;
            r_clear_pend  <= 1'b0;
            r_o_ready     <= 1'b1;
            r_o_valid     <= 1'b0;
            r_o_data      <= '0;
            for (int b = 0; b < N_BANDS; b++) begin
                for (int c = 0; c < 5; c++) begin
                    r_sh[b][c]  <= (c == 0) ? UNITY : '0;
                    r_act[b][c] <= (c == 0) ? UNITY : '0;
                end
                r_x1[b] <= '0;
                r_x2[b] <= '0;
                r_y1[b] <= '0;
                r_y2[b] <= '0;
            end
        end else begin
            r_sh <= w_sh_nxt;
            if (r_state != S_IDLE && i_commit) r_commit_pend <= 1'b1;
            if (r_state != S_IDLE && i_clear)  r_clear_pend  <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_o_ready <= 1'b1;
                    if (i_commit) r_act <= w_sh_nxt;
                    if (i_clear) begin
                        for (int b = 0; b < N_BANDS; b++) begin
                            r_x1[b] <= '0; r_x2[b] <= '0; r_y1[b] <= '0; r_y2[b] <= '0;
                        end
                    end
                    if (i_valid && r_o_ready) begin
                        r_x       <= i_data;
                        r_bypass  <= i_bypass;
                        r_band    <= '0;
                        r_term    <= 3'd0;
                        r_o_ready <= 1'b0;
                        r_state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= (r_term == 3'd0) ? w_term : r_acc + w_term;
                    if (r_term == 3'd4) begin
                        r_term  <= 3'd0;
                        r_state <= S_WB;
                    end else begin
                        r_term <= r_term + 3'd1;
                    end
                end
                S_WB: begin
                    if (!r_bypass) begin
                        r_x2[r_band] <= r_x1[r_band];
                        r_x1[r_band] <= r_x;
                        r_y2[r_band] <= r_y1[r_band];
                        r_y1[r_band] <= w_y;
                        r_x          <= w_y;
                    end
                    if (r_band == BAND_W'(N_BANDS - 1)) begin
                        r_o_data <= r_bypass ? r_x : w_y;
                        r_state  <= S_OUT;
                    end else begin
                        r_band  <= r_band + BAND_W'(1);
                        r_state <= S_MAC;
                    end
                end
                S_OUT: begin
                    if (r_o_valid && i_ready) begin
                        r_o_valid     <= 1'b0;
                        r_state       <= S_IDLE;
                        r_o_ready     <= ~(w_do_commit | w_do_clear);
                        r_commit_pend <= 1'b0;
                        r_clear_pend  <= 1'b0;
                        if (w_do_commit) r_act <= w_sh_nxt;
                        if (w_do_clear) begin
                            for (int b = 0; b < N_BANDS; b++) begin
                                r_x1[b] <= '0; r_x2[b] <= '0; r_y1[b] <= '0; r_y2[b] <= '0;
                            end
                        end
                    end else begin
                        // o_valid is registered off the S_OUT entry, one edge after the last writeback.
                        r_o_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = r_o_ready;
    assign o_valid = r_o_valid;
    assign o_data  = r_o_data;
endmodule
